// File: rtl/gift_pipe_arbiter_pkg.sv
// Shared definitions for the GIFT-128 pipe arbiter.
//   BLK_W     : width of key and plaintext/ciphertext blocks
//   req_id_e  : requester identity carried through the tag pipe
//   state_e   : DRAIN (flush stale core results) / RUN
//   tag_t     : one tag-pipe stage, {valid, id}
package gift_pipe_arbiter_pkg;

  localparam int BLK_W = 128;

  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
  typedef enum logic {ST_DRAIN = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/gift_pipe_arbiter_if.sv
// Bundle of the requester, core and response signals of gift_pipe_arbiter.
//   slave  : the arbiter's view (takes requests and core results, drives core and responses)
//   master : the environment's view (requesters, core model, response consumers)
interface gift_pipe_arbiter_if;
  import gift_pipe_arbiter_pkg::*;

  logic             inReqA_Valid;
  logic             outReqA_Ready;
  logic [BLK_W-1:0] inReqA_Key;
  logic [BLK_W-1:0] inReqA_Data;
  logic             inReqB_Valid;
  logic             outReqB_Ready;
  logic [BLK_W-1:0] inReqB_Key;
  logic [BLK_W-1:0] inReqB_Data;
  logic             outKeyWr;
  logic             outDataWr;
  logic [BLK_W-1:0] outKey;
  logic [BLK_W-1:0] outData;
  logic             inCoreValid;
  logic [BLK_W-1:0] inCoreData;
  logic             outRespA_Valid;
  logic             outRespB_Valid;
  logic [BLK_W-1:0] outRespData;
  logic             outBusy;
  logic             outErr;

  modport slave (
    input  inReqA_Valid, inReqA_Key, inReqA_Data,
    input  inReqB_Valid, inReqB_Key, inReqB_Data,
    input  inCoreValid, inCoreData,
    output outReqA_Ready, outReqB_Ready,
    output outKeyWr, outDataWr, outKey, outData,
    output outRespA_Valid, outRespB_Valid, outRespData,
    output outBusy, outErr
  );

  modport master (
    output inReqA_Valid, inReqA_Key, inReqA_Data,
    output inReqB_Valid, inReqB_Key, inReqB_Data,
    output inCoreValid, inCoreData,
    input  outReqA_Ready, outReqB_Ready,
    input  outKeyWr, outDataWr, outKey, outData,
    input  outRespA_Valid, outRespB_Valid, outRespData,
    input  outBusy, outErr
  );

endinterface

// File: rtl/gift_tag_delay.sv
// DEPTH-stage shift register of {valid, id} tags that mirrors the core
// pipeline, so the tail tells which requester owns the result leaving the core.
//   clk, rst : clock, asynchronous active-high clear
//   in_tag   : tag entering alongside the core load strobe
//   out_tag  : tag aligned with the core's output
module gift_tag_delay
  import gift_pipe_arbiter_pkg::*;
#(
  parameter int DEPTH = 42
) (
  input  logic clk,
  input  logic rst,
  input  tag_t in_tag,
  output tag_t out_tag
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  // NOTE: every element of pipe_d is assigned on every pass, so no latch is inferred.
  always_comb begin
    pipe_d[0] = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: unlike a data RAM this array is reset: a reset must discard every in-flight tag.
  // NOTE: non-blocking assignments let all stages shift off the same old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/gift_pipe_arbiter.sv
// Round-robin sharing of one pipelined GIFT-128 core between requesters A and B.
//   inClk, inRst : clock, asynchronous active-high reset
//   bus          : requester handshakes, core load/return, responses, busy, sticky error
// After reset the block drains for LATENCY+1 cycles so stale core results are
// ignored, then arbitrates, tags each issue, and routes core results back.
module gift_pipe_arbiter
  import gift_pipe_arbiter_pkg::*;
#(
  parameter int LATENCY      = 42,
  parameter int MAX_INFLIGHT = 8
) (
  input logic              inClk,
  input logic              inRst,
  gift_pipe_arbiter_if.slave bus
);

  localparam int DRAIN_W = 7;
  localparam int CNT_W   = 4;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(LATENCY + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_INFLIGHT);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  req_id_e            ptr_q, ptr_d;
  req_id_e            id_q, id_d;
  logic               err_q, err_d;
  logic               wr_q, wr_d;
  logic [BLK_W-1:0]   key_q, key_d, data_q, data_d;

  tag_t tag_in, tail;
  logic run, elig_a, elig_b, grant_a, grant_b, issue;
  logic retire_a, retire_b, resp_ok;

  // Tags enter with the load strobe, so the tail lines up with inCoreValid.
  assign tag_in = '{valid: wr_q, id: id_q};

  gift_tag_delay #(.DEPTH(LATENCY)) u_tag_delay (
    .clk     (inClk),
    .rst     (inRst),
    .in_tag  (tag_in),
    .out_tag (tail)
  );

  assign run     = (state_q == ST_RUN);
  assign elig_a  = run && bus.inReqA_Valid && (cnt_a_q < CNT_MAX);
  assign elig_b  = run && bus.inReqB_Valid && (cnt_b_q < CNT_MAX);
  assign grant_a = elig_a && (!elig_b || ptr_q == REQ_A);
  assign grant_b = elig_b && (!elig_a || ptr_q == REQ_B);
  assign issue   = grant_a || grant_b;

  // A tag at the tail retires whether or not the core delivered.
  assign retire_a = run && tail.valid && (tail.id == REQ_A);
  assign retire_b = run && tail.valid && (tail.id == REQ_B);
  assign resp_ok  = run && tail.valid && bus.inCoreValid;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    err_d   = err_q;
    wr_d    = issue;
    key_d   = key_q;
    data_d  = data_q;

    if (state_q == ST_DRAIN) begin
      drain_d = drain_q - DRAIN_W'(1);
      if (drain_q == DRAIN_W'(1)) begin
        state_d = ST_RUN;
      end
    end

    if (issue) begin
      id_d   = grant_b ? REQ_B : REQ_A;
      key_d  = grant_b ? bus.inReqB_Key  : bus.inReqA_Key;
      data_d = grant_b ? bus.inReqB_Data : bus.inReqA_Data;
      ptr_d  = other_id(id_d);
    end

    if (run && (tail.valid != bus.inCoreValid)) begin
      err_d = 1'b1;
    end

    // Issue and retire in the same cycle cancel out.
    cnt_a_d = cnt_a_q + CNT_W'(grant_a) - CNT_W'(retire_a);
    cnt_b_d = cnt_b_q + CNT_W'(grant_b) - CNT_W'(retire_b);
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q <= ST_DRAIN;
      drain_q <= DRAIN_INIT;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      ptr_q   <= REQ_A;
      id_q    <= REQ_A;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      key_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end

  assign bus.outReqA_Ready  = grant_a;
  assign bus.outReqB_Ready  = grant_b;
  assign bus.outKeyWr       = wr_q;
  assign bus.outDataWr      = wr_q;
  assign bus.outKey         = key_q;
  assign bus.outData        = data_q;
  assign bus.outRespA_Valid = resp_ok && (tail.id == REQ_A);
  assign bus.outRespB_Valid = resp_ok && (tail.id == REQ_B);
  assign bus.outRespData    = resp_ok ? bus.inCoreData : '0;
  assign bus.outBusy        = !run || (cnt_a_q != '0) || (cnt_b_q != '0);
  assign bus.outErr         = err_q;

endmodule
